// File: rtl/level_sequencer.sv
// rtl/level_sequencer.sv - game-flow controller sequencing menu, level load, play, banners and unlocks
module level_sequencer #(
  parameter int NUM_LEVELS    = 5,
  parameter int LOAD_CYCLES   = 4,
  parameter int BANNER_CYCLES = 100_000_000,
  parameter int TIMER_W       = 27
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            key_down,
  input  logic [NUM_LEVELS-1:0] level_clear,
  input  logic [NUM_LEVELS-1:0] level_fail,
  output logic [2:0]            map,
  output logic                  select,
  output logic [NUM_LEVELS:0]   map_en,
  output logic                  map_rst,
  output logic [2:0]            unlocked,
  output logic [1:0]            banner,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    S_MENU  = 3'd0,
    S_LOAD  = 3'd1,
    S_PLAY  = 3'd2,
    S_CLEAR = 3'd3,
    S_FAIL  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [2:0]         LAST_LEVEL  = 3'(NUM_LEVELS);
  localparam logic [TIMER_W-1:0] LOAD_LAST   = TIMER_W'(LOAD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] BANNER_LAST = TIMER_W'(BANNER_CYCLES - 1);
  localparam logic [NUM_LEVELS:0] MENU_EN    = {{NUM_LEVELS{1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [2:0]           map_q, map_d;
  logic [2:0]           unlocked_q, unlocked_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 armed_q, armed_d;
  logic                 select_q, select_d;
  logic [NUM_LEVELS:0]  map_en_q, map_en_d;
  logic                 map_rst_q, map_rst_d;
  logic [1:0]           banner_q, banner_d;

  logic fire;
  logic act_esc, act_sel, act_next, act_prev;
  logic cur_clear, cur_fail;
  logic load_done, banner_done;

  // One action per key press: fire only when re-armed, pick a single winner by priority
  always_comb begin
    fire     = armed_q && (key_down != 10'd0);
    act_esc  = fire && key_down[9];
    act_sel  = fire && !key_down[9] && key_down[8];
    act_next = fire && !key_down[9] && !key_down[8] && (key_down[0] || key_down[4]);
    act_prev = fire && !key_down[9] && !key_down[8] && !(key_down[0] || key_down[4])
               && (key_down[2] || key_down[6]);
    if (fire) begin
      armed_d = 1'b0;
    end else if (key_down == 10'd0) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end
  end

  // Pick out the clear/fail flags of the level currently being played; others are ignored
  always_comb begin
    cur_clear = 1'b0;
    cur_fail  = 1'b0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (map_q == 3'(i + 1)) begin
        cur_clear = level_clear[i];
        cur_fail  = level_fail[i];
      end
    end
  end

  assign load_done   = (timer_q == LOAD_LAST);
  assign banner_done = (timer_q == BANNER_LAST);

  // Next-state, cursor and unlock progression
  always_comb begin
    state_d    = state_q;
    map_d      = map_q;
    unlocked_d = unlocked_q;
    case (state_q)
      S_MENU: begin
        if (act_sel) begin
          state_d = S_LOAD;
        end else if (act_next) begin
          if (map_q < unlocked_q) map_d = map_q + 3'd1;
        end else if (act_prev) begin
          if (map_q > 3'd1) map_d = map_q - 3'd1;
        end
      end
      S_LOAD: begin
        if (load_done) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (cur_clear) begin
          state_d = S_CLEAR;
          // Beating the frontier level opens the next one
          if ((map_q == unlocked_q) && (unlocked_q < LAST_LEVEL)) begin
            unlocked_d = unlocked_q + 3'd1;
          end
        end else if (cur_fail) begin
          state_d = S_FAIL;
        end else if (act_esc) begin
          state_d = S_MENU;
        end
      end
      S_CLEAR: begin
        if (act_esc) begin
          state_d = S_MENU;
        end else if (act_sel || banner_done) begin
          if (map_q == LAST_LEVEL) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
            map_d   = map_q + 3'd1;
          end
        end
      end
      S_FAIL: begin
        if (act_esc) begin
          state_d = S_MENU;
        end else if (act_sel || banner_done) begin
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        if (act_esc || act_sel) begin
          state_d = S_MENU;
          map_d   = 3'd1;
        end
      end
      default: begin
        state_d = S_MENU;
        map_d   = 3'd1;
      end
    endcase
  end

  // Timer restarts on every state change; registered outputs decoded from the next state
  always_comb begin
    timer_d   = (state_d != state_q) ? '0 : timer_q + TIMER_W'(1);
    select_d  = (state_d != S_MENU);
    map_rst_d = (state_d == S_LOAD);
    map_en_d  = '0;
    map_en_d[0] = (state_d == S_MENU);
    for (int i = 1; i <= NUM_LEVELS; i++) begin
      map_en_d[i] = (state_d == S_PLAY) && (map_d == 3'(i));
    end
    case (state_d)
      S_CLEAR: banner_d = 2'd1;
      S_FAIL:  banner_d = 2'd2;
      S_DONE:  banner_d = 2'd3;
      default: banner_d = 2'd0;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_MENU;
      map_q      <= 3'd1;
      unlocked_q <= 3'd1;
      timer_q    <= '0;
      armed_q    <= 1'b1;
      select_q   <= 1'b0;
      map_en_q   <= MENU_EN;
      map_rst_q  <= 1'b0;
      banner_q   <= 2'd0;
    end else begin
      state_q    <= state_d;
      map_q      <= map_d;
      unlocked_q <= unlocked_d;
      timer_q    <= timer_d;
      armed_q    <= armed_d;
      select_q   <= select_d;
      map_en_q   <= map_en_d;
      map_rst_q  <= map_rst_d;
      banner_q   <= banner_d;
    end
  end

  assign state    = state_q;
  assign map      = map_q;
  assign unlocked = unlocked_q;
  assign select   = select_q;
  assign map_en   = map_en_q;
  assign map_rst  = map_rst_q;
  assign banner   = banner_q;

endmodule

// File: tb/tb_level_sequencer.sv
// tb/tb_level_sequencer.sv - scoreboard bench for level_sequencer
module tb_level_sequencer;

  localparam int NL = 5;
  localparam int LC = 4;
  localparam int BC = 8;
  localparam int TW = 27;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [9:0]    key_down = '0;
  logic [NL-1:0] level_clear = '0;
  logic [NL-1:0] level_fail = '0;
  logic [2:0]    map;
  logic          select;
  logic [NL:0]   map_en;
  logic          map_rst;
  logic [2:0]    unlocked;
  logic [1:0]    banner;
  logic [2:0]    state;

  level_sequencer #(
    .NUM_LEVELS(NL), .LOAD_CYCLES(LC), .BANNER_CYCLES(BC), .TIMER_W(TW)
  ) dut (
    .clk(clk), .rst(rst), .key_down(key_down),
    .level_clear(level_clear), .level_fail(level_fail),
    .map(map), .select(select), .map_en(map_en), .map_rst(map_rst),
    .unlocked(unlocked), .banner(banner), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int mp;
    int ul;
  } exp_t;

  exp_t sb[$];
  int n_total = 0;
  int n_pass  = 0;
  int cyc_no  = 0;

  task automatic check(input string tag, input int obs, input int expv);
    n_total++;
    if (obs == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
  endtask

  function automatic int exp_en(input int st, input int mp);
    if (st == 0) return 1;
    if (st == 2) return 1 << mp;
    return 0;
  endfunction

  function automatic int exp_banner(input int st);
    case (st)
      3: return 1;
      4: return 2;
      5: return 3;
      default: return 0;
    endcase
  endfunction

  // drive one cycle of inputs, queue the outputs expected after that edge, compare them
  task automatic cyc(input logic [9:0] k, input logic [NL-1:0] lc, input logic [NL-1:0] lf,
                     input int es, input int em, input int eu);
    exp_t e;
    @(negedge clk);
    key_down    = k;
    level_clear = lc;
    level_fail  = lf;
    e.st = es; e.mp = em; e.ul = eu;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc_no++;
    e = sb.pop_front();
    check($sformatf("c%0d state", cyc_no), int'(state), e.st);
    check($sformatf("c%0d map", cyc_no), int'(map), e.mp);
    check($sformatf("c%0d unlocked", cyc_no), int'(unlocked), e.ul);
    check($sformatf("c%0d map_en", cyc_no), int'(map_en), exp_en(e.st, e.mp));
    check($sformatf("c%0d map_rst", cyc_no), int'(map_rst), (e.st == 1) ? 1 : 0);
    check($sformatf("c%0d banner", cyc_no), int'(banner), exp_banner(e.st));
    if (e.st <= 2) check($sformatf("c%0d select", cyc_no), int'(select), (e.st == 0) ? 0 : 1);
  endtask

  task automatic load_then_play(input int m, input int u);
    for (int i = 0; i < LC - 1; i++) cyc('0, '0, '0, 1, m, u);
    cyc('0, '0, '0, 2, m, u);
  endtask

  initial begin
    // reset with keys and level flags active
    rst = 1'b1;
    cyc(10'h100, '0, '0, 0, 1, 1);
    cyc(10'h001, 5'h1f, 5'h1f, 0, 1, 1);
    rst = 1'b0;

    // hold next for 10 cycles: only level 1 unlocked, map holds
    for (int i = 0; i < 10; i++) cyc(10'h001, '0, '0, 0, 1, 1);
    cyc('0, '0, '0, 0, 1, 1);

    // launch level 1: LOAD for exactly LC cycles then PLAY
    cyc(10'h100, '0, '0, 1, 1, 1);
    load_then_play(1, 1);
    cyc('0, '0, '0, 2, 1, 1);

    // clear and fail together: clear wins, unlock 2, auto-advance after BC cycles
    cyc('0, 5'h01, 5'h01, 3, 1, 2);
    for (int i = 0; i < BC - 1; i++) cyc('0, '0, '0, 3, 1, 2);
    cyc('0, '0, '0, 1, 2, 2);
    load_then_play(2, 2);

    // flags of other levels are ignored
    cyc('0, 5'h01, 5'h04, 2, 2, 2);
    cyc('0, 5'h1d, 5'h1d, 2, 2, 2);

    // fail level 2, retry with select on the third cycle
    cyc('0, '0, 5'h02, 4, 2, 2);
    cyc('0, '0, '0, 4, 2, 2);
    cyc('0, '0, '0, 4, 2, 2);
    cyc(10'h100, '0, '0, 1, 2, 2);
    load_then_play(2, 2);

    // escape from play keeps the map
    cyc(10'h200, '0, '0, 0, 2, 2);
    cyc('0, '0, '0, 0, 2, 2);

    // clear levels 2..4, skipping each banner with select
    cyc(10'h100, '0, '0, 1, 2, 2);
    load_then_play(2, 2);
    for (int lvl = 2; lvl <= 4; lvl++) begin
      cyc('0, NL'(1 << (lvl - 1)), '0, 3, lvl, lvl + 1);
      cyc('0, '0, '0, 3, lvl, lvl + 1);
      cyc(10'h100, '0, '0, 1, lvl + 1, lvl + 1);
      load_then_play(lvl + 1, lvl + 1);
    end

    // clear the last level: full banner then DONE, no further unlock
    cyc('0, 5'h10, '0, 3, 5, 5);
    for (int i = 0; i < BC - 1; i++) cyc('0, '0, '0, 3, 5, 5);
    cyc('0, '0, '0, 5, 5, 5);
    cyc('0, '0, '0, 5, 5, 5);
    cyc(10'h200, '0, '0, 0, 1, 5);
    cyc('0, '0, '0, 0, 1, 5);

    // four next presses (first one held), then a fifth that saturates
    cyc(10'h001, '0, '0, 0, 2, 5);
    cyc(10'h001, '0, '0, 0, 2, 5);
    cyc(10'h001, '0, '0, 0, 2, 5);
    cyc('0, '0, '0, 0, 2, 5);
    for (int m = 3; m <= 5; m++) begin
      cyc(10'h010, '0, '0, 0, m, 5);
      cyc('0, '0, '0, 0, m, 5);
    end
    cyc(10'h001, '0, '0, 0, 5, 5);
    cyc('0, '0, '0, 0, 5, 5);

    // prev presses and key priority
    cyc(10'h004, '0, '0, 0, 4, 5);
    cyc('0, '0, '0, 0, 4, 5);
    cyc(10'h040, '0, '0, 0, 3, 5);
    cyc('0, '0, '0, 0, 3, 5);
    cyc(10'h005, '0, '0, 0, 4, 5);
    cyc('0, '0, '0, 0, 4, 5);
    cyc(10'h300, '0, '0, 0, 4, 5);
    cyc('0, '0, '0, 0, 4, 5);

    // select beats next; escape during LOAD ignored
    cyc(10'h101, '0, '0, 1, 4, 5);
    cyc(10'h200, '0, '0, 1, 4, 5);
    cyc('0, '0, '0, 1, 4, 5);
    cyc('0, '0, '0, 1, 4, 5);
    cyc('0, '0, '0, 2, 4, 5);

    // clear a non-frontier level, then reset mid-banner
    cyc('0, 5'h08, '0, 3, 4, 5);
    cyc('0, '0, '0, 3, 4, 5);
    rst = 1'b1;
    cyc(10'h100, '0, '0, 0, 1, 1);
    rst = 1'b0;
    cyc('0, '0, '0, 0, 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/level_sequencer.md
# level_sequencer

Game-flow controller that sequences the level maps behind the VGA pixel-address mux. It owns menu cursor movement, level launch, per-level re-initialisation, clear/fail detection, banner timing, auto-advance and level unlocking. It drives the `map`/`select` pair consumed by the address switch and the per-map enables and resets consumed by the map modules.

## Interface
Parameters:
- NUM_LEVELS, 5: number of playable maps, 1..7.
- LOAD_CYCLES, 4: cycles `map_rst` is held before play starts, ≥1.
- BANNER_CYCLES, 100_000_000: clear/fail banner duration in clk cycles, ≥2.
- TIMER_W, 27: timer width; must hold BANNER_CYCLES-1 and LOAD_CYCLES-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- key_down  in  10  decoded key levels:
  - bit0/bit4: next.
  - bit2/bit6: previous.
  - bit8: select.
  - bit9: escape.
- level_clear  in  NUM_LEVELS  bit N-1 = level N cleared (level).
- level_fail  in  NUM_LEVELS  bit N-1 = level N player death (level).
- map  out  3  current/cursor level, 1..NUM_LEVELS.
- select  out  1  0 = menu view, 1 = map view.
- map_en  out  NUM_LEVELS+1  one-hot enable.
  - bit0: menu.
  - bit N: level N, high only in PLAY.
- map_rst  out  1  re-initialise active map, high in LOAD.
- unlocked  out  3  highest selectable level.
- banner  out  2  0 none, 1 clear, 2 fail, 3 all done.
- state  out  3  MENU=0, LOAD=1, PLAY=2, CLEAR=3, FAIL=4, DONE=5.

## Operation
- Reset values:
  - state=MENU, map=1, unlocked=1, select=0.
  - map_en=bit0 only, map_rst=0, banner=0.
  - timer=0, armed=1.
- Key gating:
  - A key action fires only when armed=1 and key_down≠0. Firing clears armed.
  - armed returns to 1 on the cycle after key_down==0 is sampled.
  - Holding a key gives exactly one action.
  - Multiple bits in one cycle: escape > select > next > prev. One action only.
  - Keys sampled in a state that ignores them still clear armed.
- MENU:
  - select=0, map_en[0]=1.
  - next: map+1 if map<unlocked, else hold.
  - prev: map-1 if map>1, else hold.
  - select: go to LOAD.
  - escape: ignored.
- LOAD:
  - select=1, map_rst=1, all map_en=0.
  - Keys ignored.
  - Go to PLAY after exactly LOAD_CYCLES cycles.
- PLAY:
  - map_en[map]=1 only.
  - If level_clear[map-1], go to CLEAR. Else if level_fail[map-1], go to FAIL. Clear wins when both are set.
  - escape: go to MENU, map held.
  - clear/fail bits of non-active levels are ignored.
- CLEAR:
  - banner=1, map_en all 0.
  - On entry, if map==unlocked and unlocked<NUM_LEVELS, unlocked+1.
  - Timer expiry or select: if map==NUM_LEVELS go to DONE, else map+1 and go to LOAD.
  - escape: go to MENU with map unchanged. The unlock is kept.
- FAIL:
  - banner=2.
  - Timer expiry or select: go to LOAD with the same map (retry).
  - escape: go to MENU.
- DONE:
  - banner=3.
  - select or escape: go to MENU with map=1. unlocked is retained.
- unlocked is never decremented except by rst.

## Timing
- All outputs are registered and change on the clk edge after the causing input is sampled.
- Timer:
  - Cleared on every state entry and counts once per cycle.
  - Expires at count==BANNER_CYCLES-1, so CLEAR/FAIL last exactly BANNER_CYCLES cycles absent keys.
  - LOAD expires at count==LOAD_CYCLES-1.
- level_clear high in cycle t: state=CLEAR and banner=1 at t+1. unlocked updates at t+1.
- Key press, first armed cycle t: map/state update at t+1.
- Auto-advance: CLEAR to LOAD edge, then map_rst high for LOAD_CYCLES cycles, then map_en[map+1] high.
- rst during any state returns all outputs to reset values on the next edge, including unlocked=1.

## Test plan
All scenarios use NUM_LEVELS=5, LOAD_CYCLES=4, BANNER_CYCLES=8.
- Reset, then hold key_down[0] for 10 cycles, then release:
  - map stays 1 (unlocked=1).
  - armed drops after one sample.
  - state=MENU, map_en=000001.
- Press select in MENU:
  - state=LOAD next cycle.
  - map_rst high exactly 4 cycles.
  - Then PLAY with map_en=000010.
- In PLAY level 1, pulse level_clear=00001 and level_fail=00001 together:
  - CLEAR next cycle, banner=1, unlocked=2.
  - After 8 cycles: LOAD with map=2.
  - Then PLAY with map_en=000100.
- In PLAY level 2, assert level_fail[1]:
  - FAIL, banner=2.
  - Press select at cycle 3: LOAD immediately with map=2.
  - unlocked unchanged.
- With unlocked=5 and map=5, clear level 5:
  - CLEAR for 8 cycles, then DONE, banner=3.
  - escape: MENU, map=1, unlocked=5.
  - Four next presses, each separated by release: map=5.
  - Fifth next press: map stays 5.
- In PLAY, assert level_clear for a non-active level: no change.
- Press escape in PLAY: MENU, map held.
- Assert rst mid-CLEAR: all reset values next cycle.
